// File: rtl/jimmy_core_p.sv
// jimmy_core_p: two-cycle (fetch/execute) accumulator-style CPU core with four
// general registers, byte-wide program memory, I/O ports, a hardware call/data
// stack and a sticky stack fault flag.
module jimmy_core_p #(
    parameter int unsigned DW     = 8,
    parameter int unsigned AW     = 8,
    parameter int unsigned NPORT  = 4,
    parameter int unsigned SDEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NPORT*DW-1:0] in_port,
    output logic [NPORT-1:0]    in_strobe,
    output logic [NPORT*DW-1:0] out_port,
    output logic [NPORT-1:0]    out_strobe,
    input  logic [7:0]          inst_data_bus,
    output logic [AW-1:0]       inst_address_bus,
    output logic                halted,
    output logic                fault
);
    // Stack entries hold either a data word or a return address.
    localparam int unsigned SW  = (DW > AW) ? DW : AW;
    localparam int unsigned SPW = $clog2(SDEPTH + 1);
    localparam int unsigned SIW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

    localparam logic [3:0] FnLdi  = 4'h0;
    localparam logic [3:0] FnCmpi = 4'h1;
    localparam logic [3:0] FnInc  = 4'h2;
    localparam logic [3:0] FnDec  = 4'h3;
    localparam logic [3:0] FnIn   = 4'h4;
    localparam logic [3:0] FnOut  = 4'h5;
    localparam logic [3:0] FnPush = 4'h6;
    localparam logic [3:0] FnPop  = 4'h7;
    localparam logic [3:0] FnJmp  = 4'h8;
    localparam logic [3:0] FnCall = 4'h9;
    localparam logic [3:0] FnRet  = 4'hA;
    localparam logic [3:0] FnBeq  = 4'hB;
    localparam logic [3:0] FnBne  = 4'hC;
    localparam logic [3:0] FnBhi  = 4'hD;
    localparam logic [3:0] FnBcs  = 4'hE;
    localparam logic [3:0] FnHalt = 4'hF;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StExec  = 2'd1,
        StHalt  = 2'd2
    } state_e;

    state_e         state;
    logic [AW-1:0]  pc;
    logic [SPW-1:0] sp;
    logic [DW-1:0]  regs [4];
    logic [SW-1:0]  stack [SDEPTH];
    logic [7:0]     ir;
    logic           flag_z, flag_c, flag_n, flag_v;

    logic [3:0]     fn;
    logic [1:0]     a_idx, b_idx;
    logic [DW-1:0]  op_a, op_b, rhs, imm, in_val, res;
    logic [DW:0]    add_ext, sub_ext;
    logic           add_v, sub_v, res_c, res_v;
    logic           wr_en, set_flags, arith;
    logic [AW-1:0]  target, pc_inc;
    logic [SPW-1:0] sp_dec;
    logic [SW-1:0]  stk_top;
    logic           stk_full, stk_empty, single_op, two_byte;

    assign inst_address_bus = pc;

    // Opcodes that carry an operand byte; decided from the byte being fetched.
    always_comb begin
        two_byte = 1'b0;
        if (inst_data_bus[7:6] == 2'b10) begin
            case (inst_data_bus[5:2])
                FnLdi, FnCmpi, FnJmp, FnCall,
                FnBeq, FnBne, FnBhi, FnBcs: two_byte = 1'b1;
                default:                    two_byte = 1'b0;
            endcase
        end
    end

    // Operand selection, ALU and register/flag write decode for EXECUTE.
    always_comb begin
        single_op = (ir[7:6] == 2'b10);
        fn        = ir[5:2];
        a_idx     = ir[7] ? ir[1:0] : ir[3:2];
        b_idx     = ir[1:0];
        op_a      = regs[a_idx];
        op_b      = regs[b_idx];
        imm       = DW'(inst_data_bus);
        target    = inst_data_bus[AW-1:0];
        pc_inc    = pc + 1'b1;
        sp_dec    = sp - 1'b1;
        stk_top   = stack[sp_dec[SIW-1:0]];
        stk_full  = (sp == SPW'(SDEPTH));
        stk_empty = (sp == '0);

        in_val = '0;
        for (int p = 0; p < int'(NPORT); p++) begin
            if (int'(a_idx) == p) in_val = in_port[p*DW +: DW];
        end

        // Single-register arithmetic uses either the immediate or a constant one.
        rhs = op_b;
        if (single_op) rhs = (fn == FnCmpi) ? imm : DW'(1);
        add_ext = {1'b0, op_a} + {1'b0, rhs};
        sub_ext = {1'b0, op_a} - {1'b0, rhs};
        add_v   = (op_a[DW-1] == rhs[DW-1]) && (add_ext[DW-1] != op_a[DW-1]);
        sub_v   = (op_a[DW-1] != rhs[DW-1]) && (sub_ext[DW-1] != op_a[DW-1]);

        res       = '0;
        res_c     = 1'b0;
        res_v     = 1'b0;
        wr_en     = 1'b0;
        set_flags = 1'b0;
        arith     = 1'b0;
        if (!ir[7]) begin
            case (ir[6:4])
                3'd0: begin
                    res = add_ext[DW-1:0]; res_c = add_ext[DW]; res_v = add_v;
                    wr_en = 1'b1; set_flags = 1'b1; arith = 1'b1;
                end
                3'd1: begin
                    res = sub_ext[DW-1:0]; res_c = sub_ext[DW]; res_v = sub_v;
                    wr_en = 1'b1; set_flags = 1'b1; arith = 1'b1;
                end
                3'd2: begin res = op_a & op_b; wr_en = 1'b1; set_flags = 1'b1; end
                3'd3: begin res = op_a | op_b; wr_en = 1'b1; set_flags = 1'b1; end
                3'd4: begin res = op_a ^ op_b; wr_en = 1'b1; set_flags = 1'b1; end
                3'd5: begin res = op_b;        wr_en = 1'b1; set_flags = 1'b1; end
                3'd6: begin
                    res = sub_ext[DW-1:0]; res_c = sub_ext[DW]; res_v = sub_v;
                    set_flags = 1'b1; arith = 1'b1;
                end
                default: ;
            endcase
        end else if (single_op) begin
            case (fn)
                FnLdi: begin res = imm; wr_en = 1'b1; set_flags = 1'b1; end
                FnCmpi, FnDec: begin
                    res = sub_ext[DW-1:0]; res_c = sub_ext[DW]; res_v = sub_v;
                    wr_en = (fn == FnDec); set_flags = 1'b1; arith = 1'b1;
                end
                FnInc: begin
                    res = add_ext[DW-1:0]; res_c = add_ext[DW]; res_v = add_v;
                    wr_en = 1'b1; set_flags = 1'b1; arith = 1'b1;
                end
                FnIn: begin res = in_val; wr_en = 1'b1; set_flags = 1'b1; end
                FnPop: begin
                    res       = stk_top[DW-1:0];
                    wr_en     = !stk_empty;
                    set_flags = !stk_empty;
                end
                default: ;
            endcase
        end
    end

    // Control FSM with all architectural state and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= StFetch;
            pc         <= '0;
            sp         <= '0;
            ir         <= '0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flag_n     <= 1'b0;
            flag_v     <= 1'b0;
            out_port   <= '0;
            in_strobe  <= '1;
            out_strobe <= '1;
            halted     <= 1'b0;
            fault      <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            case (state)
                StFetch: begin
                    ir         <= inst_data_bus;
                    state      <= StExec;
                    in_strobe  <= '1;
                    out_strobe <= '1;
                    if (two_byte) pc <= pc_inc;
                end
                StExec: begin
                    state <= StFetch;
                    pc    <= pc_inc;
                    if (wr_en) regs[a_idx] <= res;
                    if (set_flags) begin
                        flag_z <= (res == '0);
                        flag_n <= res[DW-1];
                        flag_v <= res_v;
                        if (arith) flag_c <= res_c;
                    end
                    if (single_op) begin
                        case (fn)
                            FnIn: begin
                                for (int p = 0; p < int'(NPORT); p++) begin
                                    if (int'(a_idx) == p) in_strobe[p] <= 1'b0;
                                end
                            end
                            FnOut: begin
                                for (int p = 0; p < int'(NPORT); p++) begin
                                    if (int'(a_idx) == p) begin
                                        out_port[p*DW +: DW] <= op_a;
                                        out_strobe[p]        <= 1'b0;
                                    end
                                end
                            end
                            FnPush: begin
                                if (stk_full) begin
                                    fault <= 1'b1;
                                end else begin
                                    stack[sp[SIW-1:0]] <= SW'(op_a);
                                    sp                 <= sp + 1'b1;
                                end
                            end
                            FnPop: begin
                                if (stk_empty) fault <= 1'b1;
                                else           sp    <= sp_dec;
                            end
                            FnJmp: pc <= target;
                            FnCall: begin
                                if (stk_full) begin
                                    fault <= 1'b1;
                                end else begin
                                    stack[sp[SIW-1:0]] <= SW'(pc_inc);
                                    sp                 <= sp + 1'b1;
                                    pc                 <= target;
                                end
                            end
                            FnRet: begin
                                if (stk_empty) begin
                                    fault <= 1'b1;
                                end else begin
                                    sp <= sp_dec;
                                    pc <= stk_top[AW-1:0];
                                end
                            end
                            FnBeq: if (flag_z)              pc <= target;
                            FnBne: if (!flag_z)             pc <= target;
                            FnBhi: if (!flag_c && !flag_z)  pc <= target;
                            FnBcs: if (flag_c)              pc <= target;
                            FnHalt: begin
                                pc     <= pc;
                                state  <= StHalt;
                                halted <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                StHalt: begin
                    state      <= StHalt;
                    in_strobe  <= '1;
                    out_strobe <= '1;
                end
                default: begin
                    state <= StFetch;
                    pc    <= '0;
                end
            endcase
        end
    end

endmodule
